l2_port_arbiter: RTL and testbench
==================================

Name: l2_port_arbiter

Overview:
- Shares the single L2 Wishbone slave port between the instruction-fetch master (icache miss path) and the data master (dcache miss path).
- Sits between the two L1 caches and the L2 cache.
- Uses a registered grant, one transaction per grant, and round-robin fairness.
- Downstream bus signals are driven only from the granted master, with no combinational path from request to grant.

Parameters:
- ADDR_W, 12, line-address width (word address bits [15:4]).
- DATA_W, 128, line data width.
- SEL_W, 16, byte-select width (DATA_W/8).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_cyc, i_stb, i_we  in  1 each  icache-side master request.
- i_adr  in  ADDR_W  icache line address.
- i_sel  in  SEL_W  icache byte selects.
- i_dat_m  in  DATA_W  icache write data.
- i_dat_s  out  DATA_W  read data returned to icache.
- i_ack  out  1  transaction done, to icache.
- d_cyc, d_stb, d_we, d_adr, d_sel, d_dat_m, d_dat_s, d_ack: same set for the dcache side.
- l2_cyc, l2_stb, l2_we  out  1 each  to L2.
- l2_adr  out  ADDR_W  to L2.
- l2_sel  out  SEL_W  to L2.
- l2_dat_m  out  DATA_W  to L2.
- l2_dat_s  in  DATA_W  from L2.
- l2_ack  in  1  from L2.

Behaviour:
- Request definitions: req_i = i_cyc & i_stb; req_d = d_cyc & d_stb.
- States: IDLE, GRANT_I, GRANT_D. State, plus a 1-bit last register (0 = icache served last, 1 = dcache served last).
- Reset: state = IDLE, last = 1, so the icache wins the first tie. While in IDLE all l2_* outputs are 0, i_ack = 0 and d_ack = 0.
- IDLE transitions:
  - only req_i -> GRANT_I;
  - only req_d -> GRANT_D;
  - both -> grant the side not equal to last;
  - neither -> stay in IDLE.
- Grant latency: a request first visible in cycle N is granted in cycle N+1. The l2_* signals are valid from cycle N+1.
- In GRANT_x:
  - l2_cyc/stb/we/adr/sel/dat_m mirror master x combinationally.
  - x_ack = l2_ack and x_dat_s = l2_dat_s.
  - The other master sees ack = 0 and dat_s = 0.
- End of transaction: l2_ack = 1 in GRANT_x ends it.
  - Set last = x.
  - Next state: the other side if it is requesting, else IDLE.
  - Back-to-back handoff has zero idle cycles.
  - A master is never granted twice in a row while the other is requesting.
- Abort: if master x drops cyc while in GRANT_x, l2_cyc falls the same cycle and next state = IDLE. last is not updated. An l2_ack arriving in the abort cycle is discarded (x_ack = 0).
- l2_ack in IDLE is ignored.
- A master keeping cyc & stb high after its ack re-requests. It waits behind a pending other side.
- Reset asserted mid-transaction: outputs drop to reset values immediately (asynchronous). Any in-flight L2 transaction is abandoned.
- Width rules: no arithmetic on the data path. Fields pass through unchanged.

Optional Feature:
- Macro: L2_ARB_PERF_EN.
- When defined, adds three 16-bit outputs, all reset to 0:
  - arb_i_grants: completed icache transactions.
  - arb_d_grants: completed dcache transactions.
  - arb_conflicts: cycles in which both req_i and req_d are high while neither side is receiving ack.
- Each counter saturates at 16'hFFFF.
- Input perf_clear (1 bit) synchronously zeroes all three counters. If clear and increment occur in the same cycle, clear wins.
- These are intended for the counter_control memory-mapped read mux.
- When the macro is undefined: the ports and logic are absent and the arbiter behaves identically otherwise.

Test Plan:
- Reset: hold rst_n = 0 with req_i = 1 -> all l2_*, i_ack and d_ack = 0. Release -> l2_cyc = 1 one cycle later with l2_adr = i_adr = 12'h0A3.
- Single dcache write: d_we = 1, d_adr = 12'h123, d_sel = 16'h0003; L2 acks after 4 cycles -> d_ack pulses 1 cycle, i_ack stays 0, state returns to IDLE.
- Simultaneous requests from reset -> icache granted first. On its ack, GRANT_D is entered the next cycle with no IDLE cycle between.
- Both requesting continuously for 6 transactions -> grant order I, D, I, D, I, D.
- Abort: grant icache, drop i_cyc before ack, L2 asserts ack that cycle -> i_ack = 0, state = IDLE, last unchanged, so the next tie still goes to the icache.
- With L2_ARB_PERF_EN: 3 contended transactions (2 I, 1 D) with 5 overlap cycles -> arb_i_grants = 2, arb_d_grants = 1, arb_conflicts = 5. Pulse perf_clear -> all 0.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: registered-grant round-robin arbiter sharing one L2 Wishbone port between icache and dcache.
// Optional per-side grant and conflict counters are enabled by defining L2_ARB_PERF_EN.
module l2_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 128,
  parameter int SEL_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef L2_ARB_PERF_EN
  input  logic              perf_clear,
  output logic [15:0]       arb_i_grants,
  output logic [15:0]       arb_d_grants,
  output logic [15:0]       arb_conflicts,
`endif
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_adr,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [DATA_W-1:0] i_dat_m,
  output logic [DATA_W-1:0] i_dat_s,
  output logic              i_ack,
  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [SEL_W-1:0]  d_sel,
  input  logic [DATA_W-1:0] d_dat_m,
  output logic [DATA_W-1:0] d_dat_s,
  output logic              d_ack,
  output logic              l2_cyc,
  output logic              l2_stb,
  output logic              l2_we,
  output logic [ADDR_W-1:0] l2_adr,
  output logic [SEL_W-1:0]  l2_sel,
  output logic [DATA_W-1:0] l2_dat_m,
  input  logic [DATA_W-1:0] l2_dat_s,
  input  logic              l2_ack
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;
  logic [1:0] r_state, w_next;
  logic r_last, w_req_i, w_req_d, w_gnt_i, w_gnt_d, w_done_i, w_done_d;
  assign w_req_i  = i_cyc & i_stb;
  assign w_req_d  = d_cyc & d_stb;
  assign w_gnt_i  = r_state == GRANT_I;
  assign w_gnt_d  = r_state == GRANT_D;
  // an ack arriving while the master drops cyc is an abort, not a completion
  assign w_done_i = w_gnt_i & i_cyc & l2_ack;
  assign w_done_d = w_gnt_d & d_cyc & l2_ack;
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE)
      w_next = (w_req_i && (!w_req_d || r_last)) ? GRANT_I : w_req_d ? GRANT_D : IDLE;
    else if (w_gnt_i)
      w_next = !i_cyc ? IDLE : l2_ack ? (w_req_d ? GRANT_D : IDLE) : GRANT_I;
    else if (w_gnt_d)
      w_next = !d_cyc ? IDLE : l2_ack ? (w_req_i ? GRANT_I : IDLE) : GRANT_D;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_done_i) r_last <= 1'b0;
      else if (w_done_d) r_last <= 1'b1;
    end
  end
  assign l2_cyc   = (w_gnt_i & i_cyc) | (w_gnt_d & d_cyc);
  assign l2_stb   = (w_gnt_i & i_stb) | (w_gnt_d & d_stb);
  assign l2_we    = (w_gnt_i & i_we)  | (w_gnt_d & d_we);
  assign l2_adr   = w_gnt_i ? i_adr   : w_gnt_d ? d_adr   : '0;
  assign l2_sel   = w_gnt_i ? i_sel   : w_gnt_d ? d_sel   : '0;
  assign l2_dat_m = w_gnt_i ? i_dat_m : w_gnt_d ? d_dat_m : '0;
  assign i_ack    = w_done_i;
  assign d_ack    = w_done_d;
  assign i_dat_s  = w_gnt_i ? l2_dat_s : '0;
  assign d_dat_s  = w_gnt_d ? l2_dat_s : '0;
`ifdef L2_ARB_PERF_EN
  logic [15:0] r_i_grants, r_d_grants, r_conflicts;
  logic w_conflict;
  assign w_conflict = w_req_i & w_req_d & ~w_done_i & ~w_done_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_grants  <= '0;
      r_d_grants  <= '0;
      r_conflicts <= '0;
    end else begin
      r_i_grants  <= perf_clear ? '0 : (w_done_i && r_i_grants != 16'hFFFF) ? r_i_grants + 16'd1 : r_i_grants;
      r_d_grants  <= perf_clear ? '0 : (w_done_d && r_d_grants != 16'hFFFF) ? r_d_grants + 16'd1 : r_d_grants;
      r_conflicts <= perf_clear ? '0 : (w_conflict && r_conflicts != 16'hFFFF) ? r_conflicts + 16'd1 : r_conflicts;
    end
  end
  assign arb_i_grants  = r_i_grants;
  assign arb_d_grants  = r_d_grants;
  assign arb_conflicts = r_conflicts;
`endif
endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: directed bench; completed transactions are checked against a scoreboard queue on each ack.
module tb_l2_port_arbiter;
  localparam logic [11:0] I_ADR = 12'h0A3;
  localparam logic [11:0] D_ADR = 12'h123;
  logic clk = 1'b0;
  logic rst_n;
  logic i_cyc, i_stb, i_we, i_ack, d_cyc, d_stb, d_we, d_ack;
  logic [11:0] i_adr, d_adr, l2_adr;
  logic [15:0] i_sel, d_sel, l2_sel;
  logic [127:0] i_dat_m, i_dat_s, d_dat_m, d_dat_s, l2_dat_m, l2_dat_s;
  logic l2_cyc, l2_stb, l2_we, l2_ack;
`ifdef L2_ARB_PERF_EN
  logic perf_clear;
  logic [15:0] arb_i_grants, arb_d_grants, arb_conflicts;
`endif
  typedef struct {
    logic         side;
    logic [11:0]  adr;
    logic [127:0] dat;
  } exp_t;
  exp_t exp_q[$];
  exp_t m_e;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  l2_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
`ifdef L2_ARB_PERF_EN
    .perf_clear(perf_clear), .arb_i_grants(arb_i_grants),
    .arb_d_grants(arb_d_grants), .arb_conflicts(arb_conflicts),
`endif
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_sel(i_sel),
    .i_dat_m(i_dat_m), .i_dat_s(i_dat_s), .i_ack(i_ack),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_sel(d_sel),
    .d_dat_m(d_dat_m), .d_dat_s(d_dat_s), .d_ack(d_ack),
    .l2_cyc(l2_cyc), .l2_stb(l2_stb), .l2_we(l2_we), .l2_adr(l2_adr), .l2_sel(l2_sel),
    .l2_dat_m(l2_dat_m), .l2_dat_s(l2_dat_s), .l2_ack(l2_ack)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic side, input logic [127:0] dat);
    exp_q.push_back('{side, side ? D_ADR : I_ADR, dat});
  endtask

  // scoreboard: every ack must match the oldest expected transaction
  always @(negedge clk) begin
    if (rst_n && (i_ack || d_ack)) begin
      if (exp_q.size() == 0)
        chk("ack_unexpected", 128'({d_ack, i_ack}), 128'd0);
      else begin
        m_e = exp_q.pop_front();
        chk("ack_side", 128'({d_ack, i_ack}), m_e.side ? 128'd2 : 128'd1);
        chk("ack_adr", 128'(l2_adr), 128'(m_e.adr));
        chk("ack_dat", m_e.side ? d_dat_s : i_dat_s, m_e.dat);
        chk("other_dat", m_e.side ? i_dat_s : d_dat_s, 128'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b0; i_adr = I_ADR; i_sel = 16'hFFFF; i_dat_m = '0;
    d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0; d_adr = D_ADR; d_sel = '0; d_dat_m = '0;
    l2_ack = 1'b1; l2_dat_s = '0;
`ifdef L2_ARB_PERF_EN
    perf_clear = 1'b0;
`endif
    repeat (2) tick;
    chk("rst_l2_cyc", 128'(l2_cyc), 128'd0);
    chk("rst_l2_stb", 128'(l2_stb), 128'd0);
    chk("rst_l2_adr", 128'(l2_adr), 128'd0);
    chk("rst_i_ack", 128'(i_ack), 128'd0);
    chk("rst_d_ack", 128'(d_ack), 128'd0);
    l2_ack = 1'b0; rst_n = 1'b1; push(1'b0, 128'hA1);
    #1 chk("release_idle", 128'(l2_cyc), 128'd0);
    tick;
    chk("grant_i_cyc", 128'(l2_cyc), 128'd1);
    chk("grant_i_adr", 128'(l2_adr), 128'h0A3);
    l2_dat_s = 128'hA1; l2_ack = 1'b1;
    #1 chk("i_ack_pulse", 128'(i_ack), 128'd1);
    tick;
    l2_ack = 1'b0; i_cyc = 1'b0; i_stb = 1'b0;
    #1 chk("idle_after_i", 128'(l2_cyc), 128'd0);
    // single dcache write
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_sel = 16'h0003; d_dat_m = 128'hDEAD_BEEF;
    push(1'b1, 128'hB2);
    #1 chk("d_req_idle", 128'(l2_cyc), 128'd0);
    tick;
    chk("d_l2_cyc", 128'(l2_cyc), 128'd1);
    chk("d_l2_we", 128'(l2_we), 128'd1);
    chk("d_l2_adr", 128'(l2_adr), 128'h123);
    chk("d_l2_sel", 128'(l2_sel), 128'h0003);
    chk("d_l2_dat_m", l2_dat_m, 128'hDEAD_BEEF);
    repeat (3) begin
      tick;
      chk("d_ack_wait", 128'(d_ack), 128'd0);
    end
    tick;
    l2_dat_s = 128'hB2; l2_ack = 1'b1;
    #1 chk("d_ack_pulse", 128'(d_ack), 128'd1);
    chk("d_i_ack_low", 128'(i_ack), 128'd0);
    chk("d_i_dat_zero", i_dat_s, 128'd0);
    tick;
    l2_ack = 1'b0; d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0;
    #1 chk("d_back_idle", 128'(l2_cyc), 128'd0);
    chk("d_ack_done", 128'(d_ack), 128'd0);
    l2_ack = 1'b1;
    #1 chk("idle_ack_ignored", 128'({i_ack, d_ack}), 128'd0);
    tick;
    l2_ack = 1'b0;
    // simultaneous requests from reset, then alternating handoff
    rst_n = 1'b0;
    tick;
    i_cyc = 1'b1; i_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1; rst_n = 1'b1;
    for (int k = 0; k < 6; k++) push(k[0], 128'hC0DE0 + 128'(k));
    #1 chk("tie_idle", 128'(l2_cyc), 128'd0);
    tick;
    for (int k = 0; k < 6; k++) begin
      l2_dat_s = 128'hC0DE0 + 128'(k); l2_ack = 1'b1;
      #1 chk("rr_adr", 128'(l2_adr), k[0] ? 128'(D_ADR) : 128'(I_ADR));
      chk("rr_no_gap", 128'(l2_cyc), 128'd1);
      tick;
    end
    l2_ack = 1'b0; i_cyc = 1'b0; i_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
    #1 chk("drop_cyc_now", 128'(l2_cyc), 128'd0);
    tick;
    // abort: icache drops cyc while L2 acks
    i_cyc = 1'b1; i_stb = 1'b1;
    tick;
    chk("abort_grant", 128'(l2_cyc), 128'd1);
    tick;
    i_cyc = 1'b0; l2_ack = 1'b1;
    #1 chk("abort_i_ack", 128'(i_ack), 128'd0);
    chk("abort_l2_cyc", 128'(l2_cyc), 128'd0);
    tick;
    l2_ack = 1'b0; i_cyc = 1'b1; d_cyc = 1'b1; d_stb = 1'b1;
    push(1'b0, 128'hE1); push(1'b1, 128'hE2);
    #1 chk("abort_to_idle", 128'(l2_cyc), 128'd0);
    tick;
    l2_dat_s = 128'hE1; l2_ack = 1'b1;
    #1 chk("tie_after_abort", 128'(l2_adr), 128'(I_ADR));
    tick;
    l2_dat_s = 128'hE2;
    #1 chk("tie_then_d", 128'(l2_adr), 128'(D_ADR));
    tick;
    l2_ack = 1'b0; i_cyc = 1'b0; i_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
    tick;
    // asynchronous reset mid-transaction
    d_cyc = 1'b1; d_stb = 1'b1;
    tick;
    chk("pre_rst_cyc", 128'(l2_cyc), 128'd1);
    rst_n = 1'b0;
    #1 chk("async_rst_cyc", 128'(l2_cyc), 128'd0);
    chk("async_rst_adr", 128'(l2_adr), 128'd0);
    tick;
    rst_n = 1'b1; d_cyc = 1'b0; d_stb = 1'b0;
    tick;
`ifdef L2_ARB_PERF_EN
    i_cyc = 1'b1; i_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1;
    push(1'b0, 128'hF1); push(1'b1, 128'hF2); push(1'b0, 128'hF3);
    repeat (3) tick;
    l2_dat_s = 128'hF1; l2_ack = 1'b1;
    tick;
    l2_ack = 1'b0;
    repeat (2) tick;
    l2_dat_s = 128'hF2; l2_ack = 1'b1;
    tick;
    d_cyc = 1'b0; d_stb = 1'b0; l2_dat_s = 128'hF3;
    tick;
    l2_ack = 1'b0; i_cyc = 1'b0; i_stb = 1'b0;
    #1 chk("perf_i_grants", 128'(arb_i_grants), 128'd2);
    chk("perf_d_grants", 128'(arb_d_grants), 128'd1);
    chk("perf_conflicts", 128'(arb_conflicts), 128'd5);
    perf_clear = 1'b1;
    tick;
    perf_clear = 1'b0;
    chk("perf_clear", 128'({arb_i_grants, arb_d_grants, arb_conflicts}), 128'd0);
`endif
    tick;
    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
